tournament_chooser_ctrl: RTL and testbench

Controller for the tournament predictor's chooser table: an array of 2^IDX_W two-bit competition counters (Strongly_Local=0, Weakly_Local=1, Weakly_Global=2, Strongly_Global=3) held in a single-port, synchronous-read table. The block:

- sequences a post-reset initialisation sweep;
- arbitrates the single table port between fetch-stage lookups and resolve-stage updates;
- performs the update as a read-modify-write using the competition transition rule.

It sits between the fetch-side predictor mux, which consumes `rsp_use_global`, and branch resolution.

---
 rtl/tournament_chooser_ctrl.sv | 84 ++++++++
 tb/tb_tournament_chooser_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tournament_chooser_ctrl.sv
// tournament_chooser_ctrl: init sweep, port arbitration and read-modify-write update of the tournament chooser table
module tournament_chooser_ctrl #(
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = 2'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_ready,
  output logic             rsp_valid,
  output logic [1:0]       rsp_state,
  output logic             rsp_use_global,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_local_correct,
  input  logic             up_global_correct,
  output logic             up_ready,
  output logic             busy_init
);
  localparam int N = 1 << IDX_W;
  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d, upd_idx_q, upd_idx_d, mem_addr;
  logic             upd_lc_q, upd_lc_d, upd_gc_q, upd_gc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_hold_q, rsp_hold_d;
  logic [1:0]       mem [N];
  logic [1:0]       rd_data_q, mem_wdata, upd_next;
  logic             mem_we, mem_re, up_real, up_take, outcome;

  // Arbitration, table port control, transition rule and next-state logic
  always_comb begin
    up_real        = up_valid && (up_local_correct != up_global_correct);
    busy_init      = state_q == INIT;
    up_ready       = state_q == IDLE;
    lk_ready       = up_ready && !up_real;
    up_take        = up_ready && up_real;
    outcome        = rd_data_q[1] ? upd_gc_q : upd_lc_q;
    upd_next       = rd_data_q[1] ? (outcome ? 2'd3 : rd_data_q - 2'd1)
                                  : (outcome ? 2'd0 : rd_data_q + 2'd1);
    mem_we         = busy_init || state_q == UPD_WR;
    mem_re         = up_take || (lk_valid && lk_ready);
    mem_addr       = busy_init ? init_ptr_q : state_q == UPD_WR ? upd_idx_q : up_real ? up_idx : lk_idx;
    mem_wdata      = busy_init ? INIT_STATE : upd_next;
    state_d        = busy_init ? (init_ptr_q == IDX_W'(N - 1) ? IDLE : INIT) : up_take ? UPD_WR : IDLE;
    init_ptr_d     = busy_init ? init_ptr_q + 1'b1 : init_ptr_q;
    upd_idx_d      = up_take ? up_idx : upd_idx_q;
    upd_lc_d       = up_take ? up_local_correct : upd_lc_q;
    upd_gc_d       = up_take ? up_global_correct : upd_gc_q;
    rsp_valid_d    = lk_valid && lk_ready;
    rsp_hold_d     = rsp_valid_q ? rd_data_q : rsp_hold_q;
    rsp_valid      = rsp_valid_q;
    rsp_state      = rsp_valid_q ? rd_data_q : rsp_hold_q;
    rsp_use_global = rsp_state[1];
  end

  // Control and response registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      upd_idx_q   <= '0;
      upd_lc_q    <= 1'b0;
      upd_gc_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      upd_idx_q   <= upd_idx_d;
      upd_lc_q    <= upd_lc_d;
      upd_gc_q    <= upd_gc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_hold_d;
    end
  end

  // Single-port synchronous-read chooser table; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) rd_data_q <= mem[mem_addr];
  end
endmodule

// File: tb/tb_tournament_chooser_ctrl.sv
// tb_tournament_chooser_ctrl: scoreboard bench for the chooser table controller
module tb_tournament_chooser_ctrl;
  localparam int N = 64;
  logic clk = 0, rst_n = 0;
  logic lk_valid = 0, up_valid = 0, up_lc = 0, up_gc = 0;
  logic [5:0] lk_idx = 0, up_idx = 0;
  logic lk_ready, rsp_valid, rsp_use_global, up_ready, busy_init;
  logic [1:0] rsp_state;
  int passed = 0, total = 0, cyc = 0, last_st = 0;
  int ref_tbl [N];
  bit blocked = 0;
  typedef struct { int due; int st; } exp_t;
  exp_t q[$];

  tournament_chooser_ctrl #(.IDX_W(6), .INIT_STATE(2'd1)) dut (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_state(rsp_state), .rsp_use_global(rsp_use_global),
    .up_valid(up_valid), .up_idx(up_idx), .up_local_correct(up_lc), .up_global_correct(up_gc),
    .up_ready(up_ready), .busy_init(busy_init));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // chooser counter saturates toward whichever predictor was right
  function automatic int model_next(int s, bit lc, bit gc);
    if (gc && !lc) return (s < 3) ? s + 1 : 3;
    return (s > 0) ? s - 1 : 0;
  endfunction

  // monitor: pops the scoreboard when a response is due, otherwise checks hold
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_st = 0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_state", rsp_state, q[0].st);
      check("rsp_use_global", rsp_use_global, q[0].st / 2);
      last_st = q[0].st;
      void'(q.pop_front());
    end else begin
      check("rsp_unexpected", rsp_valid, 0);
      check("rsp_hold", rsp_state, last_st);
    end
  end

  task automatic step(input bit lv, input int li, input bit uv, input int ui,
                      input bit lc, input bit gc, input int lexp, output bit lacc);
    bit real_up, e_up, e_lk;
    @(posedge clk); #1;
    lk_valid = lv; lk_idx = 6'(li); up_valid = uv; up_idx = 6'(ui); up_lc = lc; up_gc = gc;
    @(negedge clk);
    real_up = uv && (lc != gc);
    e_up = !blocked;
    e_lk = !blocked && !real_up;
    check("up_ready", up_ready, e_up);
    check("lk_ready", lk_ready, e_lk);
    check("busy_init", busy_init, 0);
    blocked = 0;
    lacc = lv && e_lk;
    if (lacc) q.push_back('{due: cyc + 1, st: (lexp >= 0) ? lexp : ref_tbl[li]});
    if (uv && e_up && real_up) begin
      ref_tbl[ui] = model_next(ref_tbl[ui], lc, gc);
      blocked = 1;
    end
  endtask

  task automatic lookup(input int idx, input int lexp);
    bit acc = 0;
    for (int i = 0; i < 8 && !acc; i++) step(1, idx, 0, 0, 0, 0, lexp, acc);
    if (!acc) check("lookup_accept_timeout", 0, 1);
  endtask

  task automatic update(input int idx, input bit lc, input bit gc);
    bit acc;
    step(0, 0, 1, idx, lc, gc, -1, acc);
  endtask

  task automatic assert_reset();
    @(posedge clk); #1;
    rst_n = 0; lk_valid = 1; up_valid = 1; up_lc = 0; up_gc = 1;
    @(negedge clk);
    check("rst_busy_init", busy_init, 1);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_up_ready", up_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_state", rsp_state, 0);
    check("rst_use_global", rsp_use_global, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1; lk_valid = 0; up_valid = 0;
    blocked = 0;
    foreach (ref_tbl[i]) ref_tbl[i] = 1;
  endtask

  task automatic init_sweep();
    int n = 0, bad = 0;
    release_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_init) break;
      n++;
      if (lk_ready || up_ready) bad++;
    end
    check("init_length", n, N);
    check("init_ready_low", bad, 0);
  endtask

  initial begin
    bit acc;
    assert_reset();
    init_sweep();
    lookup(0, 1);
    lookup(37, 1);
    lookup(63, 1);
    update(5, 0, 1); lookup(5, 2);
    update(5, 0, 1); lookup(5, 3);
    update(5, 0, 1); lookup(5, 3);
    update(5, 0, 1); lookup(5, 3);
    update(5, 1, 0); lookup(5, 2);
    step(0, 0, 0, 0, 0, 0, -1, acc);
    update(5, 0, 1);
    assert_reset();
    init_sweep();
    lookup(5, 1);
    step(1, 9, 1, 9, 1, 1, 1, acc);
    step(0, 0, 1, 3, 0, 1, -1, acc);
    step(1, 4, 1, 3, 0, 1, -1, acc);
    step(1, 4, 0, 0, 0, 0, -1, acc);
    step(1, 4, 0, 0, 0, 0, 1, acc);
    update(7, 1, 0);
    lookup(7, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), -1, acc);
    for (int i = 0; i < 8; i++) lookup(i, -1);
    step(0, 0, 0, 0, 0, 0, -1, acc);
    assert_reset();
    @(posedge clk); #1;
    rst_n = 1; lk_valid = 0; up_valid = 0;
    repeat (19) @(posedge clk);
    assert_reset();
    init_sweep();
    lookup(20, 1);
    lookup(7, 1);
    step(0, 0, 0, 0, 0, 0, -1, acc);
    step(0, 0, 0, 0, 0, 0, -1, acc);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
